// File: rtl/board_mem_arbiter_pkg.sv
// Shared board geometry, owner-tag encoding and pipeline tag layout for the board RAM arbiter.
package board_mem_arbiter_pkg;

  localparam int BOARD_W      = 10;
  localparam int BOARD_H      = 20;
  localparam int COLOR_W      = 3;
  localparam int BOARD_CELLS  = BOARD_W * BOARD_H;
  localparam int STARVE_LIMIT = 16;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_DISP = 2'd1,
    OWNER_GAME = 2'd2
  } owner_t;

  // owner routes mem_rdata; the flags cover results that never touch the RAM
  typedef struct packed {
    owner_t owner;
    logic   pix_zero;
    logic   pix_hold;
    logic   game_zero;
  } tag_t;

  localparam tag_t TAG_IDLE = '{owner: OWNER_NONE, pix_zero: 1'b0, pix_hold: 1'b0, game_zero: 1'b0};

endpackage

// File: rtl/board_mem_arbiter_addr_calc.sv
// Maps a print position onto a board cell index and flags positions outside the board.
module board_addr_calc #(
  parameter int BOARD_W = board_mem_arbiter_pkg::BOARD_W,
  parameter int BOARD_H = board_mem_arbiter_pkg::BOARD_H
) (
  input  logic [9:0] count_x,
  input  logic [9:0] count_y,
  output logic [7:0] cell_idx,
  output logic       out_of_range
);

  // index is deliberately evaluated at 8 bits; only in-range positions use it
  assign cell_idx     = count_y[7:0] * 8'(BOARD_W) + count_x[7:0];
  assign out_of_range = (count_x >= 10'(BOARD_W)) || (count_y >= 10'(BOARD_H));

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: display fetch has priority over game access.
// Define BOARD_ARB_STARVE_GUARD_EN to let a starved game request steal one display slot.
module board_mem_arbiter #(
  parameter int BOARD_W      = board_mem_arbiter_pkg::BOARD_W,
  parameter int BOARD_H      = board_mem_arbiter_pkg::BOARD_H,
  parameter int COLOR_W      = board_mem_arbiter_pkg::COLOR_W,
  parameter int STARVE_LIMIT = board_mem_arbiter_pkg::STARVE_LIMIT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               disp_active,
  input  logic [9:0]         count_x,
  input  logic [9:0]         count_y,
  input  logic               game_req,
  input  logic               game_we,
  input  logic [7:0]         game_addr,
  input  logic [COLOR_W-1:0] game_wdata,
  output logic               game_gnt,
  output logic [COLOR_W-1:0] game_rdata,
  output logic               game_rvalid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [7:0]         mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_valid
);
  import board_mem_arbiter_pkg::*;

  localparam int CELLS = BOARD_W * BOARD_H;

  logic [7:0]         disp_idx;
  logic               disp_oor;
  logic               steal;
  logic               disp_own;
  logic               game_own;
  logic               game_in_range;
  tag_t               tag_next;
  tag_t               tag_pipe_reg [2];
  logic [COLOR_W-1:0] pix_color_reg;
  logic [COLOR_W-1:0] game_rdata_reg;

  board_addr_calc #(
    .BOARD_W(BOARD_W),
    .BOARD_H(BOARD_H)
  ) u_addr_calc (
    .count_x     (count_x),
    .count_y     (count_y),
    .cell_idx    (disp_idx),
    .out_of_range(disp_oor)
  );

`ifdef BOARD_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;

  assign steal = disp_active && game_req && (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (game_own)
      starve_cnt_next = '0;
    else if (game_req && (starve_cnt_reg < CNT_W'(STARVE_LIMIT)))
      starve_cnt_next = starve_cnt_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) starve_cnt_reg <= '0;
    else          starve_cnt_reg <= starve_cnt_next;
  end
`else
  // display always wins; the limit only matters when the guard is built in
  assign steal = (STARVE_LIMIT < 0);
`endif

  assign game_in_range = (int'(game_addr) < CELLS);
  assign disp_own      = disp_active && !steal;
  assign game_own      = !disp_own && game_req;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    game_gnt  = 1'b0;
    tag_next  = TAG_IDLE;
    if (disp_own) begin
      if (!disp_oor) begin
        mem_en         = 1'b1;
        mem_addr       = disp_idx;
        tag_next.owner = OWNER_DISP;
      end else begin
        tag_next.pix_zero = 1'b1;
      end
    end else if (game_own) begin
      game_gnt          = 1'b1;
      tag_next.pix_hold = steal;
      if (game_in_range) begin
        mem_en    = 1'b1;
        mem_we    = game_we;
        mem_addr  = game_addr;
        mem_wdata = game_wdata;
        if (!game_we) tag_next.owner = OWNER_GAME;
      end else begin
        tag_next.game_zero = !game_we;
      end
    end
    // RAM port and grant stay quiet for the whole reset window
    if (!reset_n) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      game_gnt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe_reg[0] <= TAG_IDLE;
      tag_pipe_reg[1] <= TAG_IDLE;
      pix_color_reg   <= '0;
      game_rdata_reg  <= '0;
    end else begin
      tag_pipe_reg[0] <= tag_next;
      tag_pipe_reg[1] <= tag_pipe_reg[0];
      if (tag_pipe_reg[0].owner == OWNER_DISP) pix_color_reg <= mem_rdata;
      else if (tag_pipe_reg[0].pix_zero)       pix_color_reg <= '0;
      if (tag_pipe_reg[0].owner == OWNER_GAME) game_rdata_reg <= mem_rdata;
      else if (tag_pipe_reg[0].game_zero)      game_rdata_reg <= '0;
    end
  end

  assign pix_color   = pix_color_reg;
  assign pix_valid   = (tag_pipe_reg[1].owner == OWNER_DISP) || tag_pipe_reg[1].pix_zero
                       || tag_pipe_reg[1].pix_hold;
  assign game_rdata  = game_rdata_reg;
  assign game_rvalid = (tag_pipe_reg[1].owner == OWNER_GAME) || tag_pipe_reg[1].game_zero;

endmodule
